// File: rtl/adder_8_slice.sv
// 3-bit + 3-bit + carry-in ripple-carry slice with flat scalar ports, result on po3..po0.
// Define ADDER_8_SLICE_REG_OUT_EN to register the result (1-cycle latency, async clear).
module adder_8_slice (
    input  logic clk,
    input  logic rst_n,
    input  logic pi6,
    input  logic pi5,
    input  logic pi4,
    input  logic pi3,
    input  logic pi2,
    input  logic pi1,
    input  logic pi0,
    output logic po3,
    output logic po2,
    output logic po1,
    output logic po0
);

    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] c;
    logic [2:0] s;
    logic [3:0] sum;

    assign a    = {pi6, pi5, pi4};
    assign b    = {pi3, pi2, pi1};
    assign c[0] = pi0;

    // Explicit ripple chain so the carry path matches the partitioned datapath netlist.
    for (genvar i = 0; i < 3; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign sum = {c[3], s};

`ifdef ADDER_8_SLICE_REG_OUT_EN
    logic [3:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 4'b0000;
        end else begin
            sum_q <= sum;
        end
    end

    assign {po3, po2, po1, po0} = sum_q;
`else
    // Clock and reset are part of the fixed port list but unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;

    assign {po3, po2, po1, po0} = sum;
`endif

endmodule

// File: tb/tb_adder_8_slice.sv
// Directed-vector and exhaustive bench for adder_8_slice; follows ADDER_8_SLICE_REG_OUT_EN
// to switch between same-delta and one-edge latency checking.
module tb_adder_8_slice;

    logic clk;
    logic rst_n;
    logic pi6, pi5, pi4, pi3, pi2, pi1, pi0;
    logic po3, po2, po1, po0;

    int n_vec;
    int n_err;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [6:0] in;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[6];

    adder_8_slice dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pi6  (pi6),
        .pi5  (pi5),
        .pi4  (pi4),
        .pi3  (pi3),
        .pi2  (pi2),
        .pi1  (pi1),
        .pi0  (pi0),
        .po3  (po3),
        .po2  (po2),
        .po1  (po1),
        .po0  (po0)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic set_in(input logic [6:0] v);
        {pi6, pi5, pi4, pi3, pi2, pi1, pi0} = v;
    endtask

    task automatic drive(input logic [6:0] v);
`ifdef ADDER_8_SLICE_REG_OUT_EN
        @(negedge clk);
`endif
        set_in(v);
    endtask

    task automatic settle();
`ifdef ADDER_8_SLICE_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    // Scoreboard
    task automatic check(input string name);
        logic [3:0] exp;
        logic [3:0] act;
        act = {po3, po2, po1, po0};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, got %b", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s: in=%b got %b expected %b", name,
                         {pi6, pi5, pi4, pi3, pi2, pi1, pi0}, act, exp);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{7'b0000000, 4'b0000};
        vecs[1] = '{7'b0000001, 4'b0001};
        vecs[2] = '{7'b0110110, 4'b0110};
        vecs[3] = '{7'b1001000, 4'b1000};
        vecs[4] = '{7'b1111111, 4'b1111};
        vecs[5] = '{7'b1110000, 4'b0111};

        rst_n = 1'b0;
        set_in(7'b0000000);
        #1;
        exp_q.push_back(4'b0000);
        check("reset_state");

`ifdef ADDER_8_SLICE_REG_OUT_EN
        drive(7'b1111111);
        @(posedge clk);
        #1;
        exp_q.push_back(4'b0000);
        check("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(4'b1111);
        check("first_capture");

        #2;
        set_in(7'b0000000);
        #1;
        exp_q.push_back(4'b1111);
        check("hold_between_edges");

        rst_n = 1'b0;
        #1;
        exp_q.push_back(4'b0000);
        check("async_reset");

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(4'b0000);
        check("pending_discarded");
`else
        set_in(7'b1111111);
        #1;
        exp_q.push_back(4'b1111);
        check("reset_no_effect");
        rst_n = 1'b1;
`endif

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].in);
            exp_q.push_back(vecs[i].exp);
            settle();
            check($sformatf("table_%0d", i));
        end

        for (int v = 0; v < 128; v++) begin
            logic [6:0] in7;
            int a_val;
            int b_val;
            int total;
            in7   = v[6:0];
            a_val = int'(in7[6:4]);
            b_val = int'(in7[3:1]);
            total = a_val + b_val + int'(in7[0]);
            drive(in7);
            exp_q.push_back(total[3:0]);
            settle();
            check($sformatf("sweep_%0d", v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
